// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: funct3 codes, FSM states
// and the store lane-mask / data-replication helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } st_enc_t;

  // Byte enables and lane-replicated data for a legal store.
  function automatic st_enc_t store_encode(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] wd);
    st_enc_t e;
    case (f3)
      F3_B: begin
        e.mask = 4'b0001 << lo;
        e.data = {4{wd[7:0]}};
      end
      F3_H: begin
        e.mask = 4'b0011 << {lo[1], 1'b0};
        e.data = {2{wd[15:0]}};
      end
      default: begin
        e.mask = 4'b1111;
        e.data = wd;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core request/response and memory data-port signals of the load/store port.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a memory word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_mem_data,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0]        w_lane;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_lane = i_mem_data >> {i_addr_lo, 3'b000};
  assign w_byte = w_lane[7:0];
  assign w_half = w_lane[15:0];

  always_comb begin
    o_data = w_lane;
    case (i_funct3)
      F3_B:    o_data = 32'(w_byte);
      F3_H:    o_data = 32'(w_half);
      F3_BU:   o_data = {24'd0, w_lane[7:0]};
      F3_HU:   o_data = {16'd0, w_lane[15:0]};
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding RV32 load/store initiator for a registered-read data RAM.
// Faulting requests answer immediately without touching memory.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int RAM_SIZE = 16384
)(
  input  logic            clk,
  input  logic            resetn,
  lsu_mem_port_if.slave   bus
);

  lsu_state_e  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        w_accept, w_illegal, w_misalign, w_range, w_fault;
  logic [31:0] w_word_idx, w_load_data;
  st_enc_t     w_st;

  assign w_word_idx    = {2'b00, bus.req_addr[31:2]};
  assign w_st          = store_encode(bus.req_funct3, bus.req_addr[1:0], bus.req_wdata);
  assign bus.req_ready = (r_state == IDLE);
  assign w_accept      = bus.req_ready && bus.req_valid;

  always_comb begin
    w_illegal  = bus.req_we ? (bus.req_funct3 > F3_W)
                            : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    w_misalign = 1'b0;
    if (bus.req_funct3[1:0] == 2'b01)
      w_misalign = bus.req_addr[0];
    else if (bus.req_funct3[1:0] == 2'b10)
      w_misalign = |bus.req_addr[1:0];
    w_range = (w_word_idx >= 32'(RAM_SIZE));
    w_fault = w_illegal || w_misalign || w_range;
  end

  lsu_load_align u_align (
    .i_mem_data (bus.mem_data),
    .i_addr_lo  (r_addr_lo),
    .i_funct3   (r_funct3),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fault ? RESP : ACCESS;
      ACCESS:  w_next = r_we ? RESP : WAIT;
      WAIT:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs; mem_wmask and resp_valid default to 0 every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.mem_addr   <= '0;
      bus.mem_wmask  <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_fault <= 1'b0;
      r_we           <= 1'b0;
      r_funct3       <= '0;
      r_addr_lo      <= '0;
    end else begin
      bus.mem_wmask  <= '0;
      bus.resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_we      <= bus.req_we;
          r_funct3  <= bus.req_funct3;
          r_addr_lo <= bus.req_addr[1:0];
          if (w_fault) begin
            bus.resp_valid <= 1'b1;
            bus.resp_fault <= 1'b1;
            bus.resp_rdata <= '0;
          end else begin
            bus.mem_addr  <= w_word_idx;
            bus.mem_wmask <= bus.req_we ? w_st.mask : 4'b0000;
            bus.mem_wdata <= w_st.data;
          end
        end
        ACCESS: if (r_we) bus.resp_valid <= 1'b1;
        WAIT: begin
          bus.resp_rdata <= w_load_data;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          bus.resp_fault <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-level reference model plus a registered-read RAM.
module tb_lsu_mem_port;
  localparam int RAM_SIZE = 16384;
  localparam int AW       = $clog2(RAM_SIZE);

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  lsu_mem_port_if bus();

  lsu_mem_port #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [31:0] mem [RAM_SIZE];
  always @(posedge clk) begin
    bus.mem_data <= mem[bus.mem_addr[AW-1:0]];
    for (int j = 0; j < 4; j++)
      if (bus.mem_wmask[j]) mem[bus.mem_addr[AW-1:0]][8*j +: 8] <= bus.mem_wdata[8*j +: 8];
  end

  logic [7:0] ref_b [4*RAM_SIZE];

  typedef struct { int due; bit flt; logic [31:0] rd; } rsp_t;
  typedef struct { int c; bit we; logic [31:0] ad; logic [3:0] m; logic [31:0] wd; } acc_t;
  rsp_t rq[$];
  acc_t wq[$];

  int cyc = 0;
  int busy_until = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] e_rd, e_wl;
  logic [3:0]  e_m;
  bit          e_flt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Transaction-level reference: faults, byte-array memory, lane mask and replication.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit flt, output logic [31:0] rd,
                       output logic [3:0] m, output logic [31:0] wl);
    int  sz;
    bit  ill, mis, rng;
    longint wi;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    case (f3[1:0])
      2'd0:    sz = 1;
      2'd1:    sz = 2;
      default: sz = 4;
    endcase
    mis = (int'(a[1:0]) % sz) != 0;
    wi  = longint'(a) / 4;
    rng = wi >= RAM_SIZE;
    flt = ill || mis || rng;
    rd = '0; m = '0; wl = '0;
    if (flt) return;
    if (we) begin
      for (int i = 0; i < sz; i++) begin
        ref_b[int'(a) + i] = wd[8*i +: 8];
        m[int'(a[1:0]) + i] = 1'b1;
      end
      for (int j = 0; j < 4; j++) wl[8*j +: 8] = wd[8*(j % sz) +: 8];
    end else begin
      for (int i = 0; i < sz; i++) rd = rd | (32'(ref_b[int'(a) + i]) << (8*i));
      if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | ~((32'd1 << (8*sz)) - 32'd1);
    end
  endtask

  // Drives one request (valid set immediately, held while busy), records expectations.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int w = 0;
    int lat;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (!bus.req_ready && w < 50) begin @(negedge clk); #1; w++; end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    model(we, f3, a, wd, e_flt, e_rd, e_m, e_wl);
    lat = e_flt ? 1 : (we ? 2 : 3);
    rq.push_back('{due: cyc + lat, flt: e_flt, rd: e_rd});
    if (!e_flt) wq.push_back('{c: cyc + 1, we: we, ad: a >> 2, m: e_m, wd: e_wl});
    busy_until = cyc + lat;
    @(negedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_fault", 32'(bus.resp_fault), 32'(rq[0].flt));
        chk("resp_rdata", bus.resp_rdata, rq[0].rd);
        void'(rq.pop_front());
      end else begin
        chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
        chk("resp_fault_idle", 32'(bus.resp_fault), 32'd0);
        chk("resp_rdata_idle", bus.resp_rdata, 32'd0);
      end
      chk("req_ready", 32'(bus.req_ready), 32'(cyc > busy_until));
      if (wq.size() > 0 && wq[0].c == cyc) begin
        chk("mem_addr", bus.mem_addr, wq[0].ad);
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(wq[0].m));
        if (wq[0].we) chk("mem_wdata", bus.mem_wdata, wq[0].wd);
        void'(wq.pop_front());
      end else begin
        chk("mem_wmask_idle", 32'(bus.mem_wmask), 32'd0);
      end
    end
  end

  initial begin
    int w;
    logic [31:0] a;
    bit we, hold;
    logic [2:0] f3;
    for (int i = 0; i < RAM_SIZE; i++) mem[i] = '0;
    for (int i = 0; i < 4*RAM_SIZE; i++) ref_b[i] = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    busy_until = cyc;
    chk_en = 1'b1;
    resetn = 1'b1;

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_mask_lit", 32'(e_m), 32'hF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_lit", e_rd, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
    chk("sb_mask_lit", 32'(e_m), 32'h8);
    chk("sb_wdata_lit", e_wl, 32'hA5A5A5A5);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    chk("lb_lit", e_rd, 32'hFFFFFFA5);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    chk("lbu_lit", e_rd, 32'h000000A5);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_after_sb_lit", e_rd, 32'hA5ADBEEF);
    issue(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0);
    chk("sh_mask_lit", 32'(e_m), 32'hC);
    issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
    chk("lh_lit", e_rd, 32'hFFFF8001);
    issue(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
    chk("lhu_lit", e_rd, 32'h00008001);

    issue(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
    chk("flt_lw_mis_lit", 32'(e_flt), 32'd1);
    issue(1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, 1'b0);
    chk("flt_sh_mis_lit", 32'(e_flt), 32'd1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    chk("flt_f3_lit", 32'(e_flt), 32'd1);
    issue(1'b1, 3'b010, 32'(4*RAM_SIZE), 32'h55555555, 1'b0);
    chk("flt_range_lit", 32'(e_flt), 32'd1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_unchanged_lit", e_rd, 32'hA5ADBEEF);

    issue(1'b1, 3'b010, 32'(4*(RAM_SIZE-1)), 32'h12345678, 1'b0);
    chk("top_word_legal_lit", 32'(e_flt), 32'd0);
    issue(1'b0, 3'b010, 32'(4*(RAM_SIZE-1)), 32'h0, 1'b0);
    chk("top_word_lw_lit", e_rd, 32'h12345678);

    // Reset during WAIT of a load: no response, outputs cleared.
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    @(negedge clk); #1;
    resetn = 1'b0;
    rq.delete();
    wq.delete();
    busy_until = cyc;
    @(negedge clk); #1;
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("mid_rst_rdata", bus.resp_rdata, 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    resetn = 1'b1;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    chk("lw_after_rst_lit", e_rd, 32'hA5ADBEEF);

    issue(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
    chk("b2b_lw_lit", e_rd, 32'hCAFEF00D);
    issue(1'b0, 3'b000, 32'h31, 32'h0, 1'b0);
    chk("b2b_lb_lit", e_rd, 32'hFFFFFFF0);

    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1, 2:    a = 32'(4*RAM_SIZE - 8) + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 63));
      endcase
      hold = ($urandom_range(0, 2) == 0) && (k != 299);
      issue(we, f3, a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
    end
    bus.req_valid = 1'b0;

    w = 0;
    while ((rq.size() > 0 || wq.size() > 0) && w < 20) begin @(negedge clk); #1; w++; end
    chk("drain_pending", 32'(rq.size() + wq.size()), 32'd0);
    @(negedge clk); #1;

    for (int i = 0; i < 16; i++)
      chk("mem_low_word", mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
    for (int i = RAM_SIZE - 4; i < RAM_SIZE; i++)
      chk("mem_top_word", mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the data port of the simulation memory (mem_addr / mem_wmask / mem_wdata in, mem_data out).
- Takes one byte-addressed RV32 load/store request at a time from the core. Converts it to a word index, byte write mask and lane-replicated write data.
- Aligns and sign/zero-extends load data.
- Flags misaligned, illegal or out-of-range accesses as faults without touching memory.

Parameters:
RAM_SIZE, 16384, number of 32-bit words in data RAM; word index >= RAM_SIZE is a fault.

Ports:
clk  in  1  clock; all state updates on rising edge.
resetn  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 funct3 (size/sign).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores/faults.
resp_fault  out  1  qualifies resp_valid; access not performed.
mem_addr  out  32  word index to memory = {2'b00, addr[31:2]}.
mem_wmask  out  4  byte write enables to memory.
mem_wdata  out  32  lane-replicated write data.
mem_data  in  32  memory read data; registered by memory, valid the cycle after mem_addr.

Behaviour:
- Reset (resetn low at an edge): state=IDLE, mem_addr=0, mem_wmask=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_fault=0. All outputs registered except req_ready.
- Reset mid-operation: the transaction is dropped and no response is issued. A store whose ACCESS cycle coincides with the reset edge still commits, because memory has no reset.
- States: IDLE, ACCESS, WAIT, RESP.
  - IDLE + accept, legal: load the mem_* registers and go to ACCESS.
  - IDLE + accept, fault: go to RESP with resp_fault=1. mem_addr and mem_wmask are unchanged.
  - ACCESS: mem_wmask is nonzero only here, only for stores. Exactly one write per store. Store goes to RESP; load goes to WAIT.
  - WAIT: mem_data holds the word read during ACCESS. Register the extracted value into resp_rdata and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_valid/resp_fault/resp_rdata return to 0 the next cycle.
- Latency, counted from the accept edge to the resp_valid cycle: load 3 cycles, store 2, fault 1. Minimum spacing between accepts is latency+1.
- mem_addr holds its last value outside ACCESS/WAIT. mem_wmask=0 in every state except ACCESS.
- Store encoding (funct3: 000 SB, 001 SH, 010 SW):
  - SB: wmask = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111; wdata = req_wdata.
- Load decode (funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU):
  - Select lane = mem_data >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- Faults, checked in this order (all yield resp_fault=1, resp_rdata=0):
  1. Illegal funct3: any store funct3 not in {000,001,010}; any load funct3 in {011,110,111}.
  2. Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  3. Range: addr[31:2] >= RAM_SIZE.
- Boundary: word index RAM_SIZE-1 is legal; RAM_SIZE is a fault. Address arithmetic never wraps. No request is held while busy; req_valid in non-IDLE states is ignored.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum typedef (IDLE, ACCESS, WAIT, RESP), store-mask/replication function.
- One sub-module, lsu_load_align: combinational (mem_data, addr[1:0], funct3) -> 32-bit extended data. Instantiated in the WAIT path.

Test Plan:
- Bench connects lsu_mem_port to the simulation memory.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_addr=4, mem_wmask=1111 for one cycle; load resp_rdata=0xDEADBEEF, resp_valid exactly 3 cycles after accept.
- SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13 -> wmask=1000, wdata=0xA5A5A5A5; LB=0xFFFFFFA5, LBU=0x000000A5; other bytes of word 4 unchanged (LW 0x10 = 0xA5ADBEEF).
- SH 0x22 data 0x00008001, then LH 0x22 and LHU 0x22 -> wmask=1100; LH=0xFFFF8001, LHU=0x00008001.
- LW 0x11, SH 0x21, load funct3=011, SW addr 4*RAM_SIZE -> each resp_fault=1 one cycle after accept, resp_rdata=0, mem_wmask stays 0, memory unchanged.
- Pull resetn low during WAIT of LW 0x10 -> no resp_valid, outputs 0 next cycle, req_ready=1. A following LW 0x10 returns correct data.
- Back-to-back requests with req_valid held high -> req_ready low in ACCESS/WAIT/RESP. Second request accepted the cycle after resp_valid and never lost.
